prbs9_checker: RTL and testbench
================================

PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, meaning consecutive correct predictions needed to lock.
REQ-002 SHALL have parameter LOSS_THR, default 4, meaning errors within one window that force loss of lock.
REQ-003 SHALL have parameter WIN_LEN, default 64, meaning length of the error window in valid bits.
REQ-004 SHALL have parameter ERR_W, default 16, meaning width of the error counter.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  in_bit is sampled on this cycle.
REQ-008 SHALL have port in_bit  input  1  received serial PRBS bit, oldest first.
REQ-009 SHALL have port clr_count  input  1  synchronous clear of err_count and lost.
REQ-010 SHALL have port locked  output  1  checker is in LOCKED.
REQ-011 SHALL have port err_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 SHALL have port err_count  output  ERR_W  saturating count of mismatches while LOCKED.
REQ-013 SHALL have port lost  output  1  sticky: lock was lost since reset or the last clr_count.

Function
REQ-014 SHALL hold a 9-bit history h: on each accepted bit b, h <= {b, h[8:1]}, so h[8] is newest.
REQ-015 SHALL compute prediction p = h[8]^h[7]^h[6]^h[3]^h[0] (recurrence s[n+9]=s[n+8]^s[n+7]^s[n+6]^s[n+3]^s[n]).
REQ-016 SHALL ignore in_bit and hold all state except clr_count effects on cycles with in_valid=0.
REQ-017 SHALL implement states HUNT, CHECK and LOCKED.
REQ-018 HUNT: SHALL shift received bits into h and count 9 accepted bits, then go to CHECK; if h is all-zero at that point, it SHALL restart the 9-bit load in HUNT.
REQ-019 CHECK: SHALL compare each accepted bit with p and shift the received bit into h.
REQ-020 CHECK: after LOCK_CNT consecutive matches it SHALL go to LOCKED; any mismatch SHALL go to HUNT and restart the 9-bit load.
REQ-021 LOCKED: SHALL shift p (not the received bit) into h as a free-running reference, so one channel error yields exactly one mismatch.
REQ-022 LOCKED mismatch: err_pulse SHALL be 1 on the cycle after the accepted bit; err_count SHALL increment and saturate at 2^ERR_W-1.
REQ-023 LOCKED: SHALL count accepted bits modulo WIN_LEN and count errors per window; both counts SHALL reset at each window wrap.
REQ-024 LOCKED: the LOSS_THR-th error in one window SHALL force a transition to HUNT, set lost, and restart the load.
REQ-025 locked SHALL be registered and equal (state==LOCKED), asserting the cycle after the LOCK_CNT-th match.
REQ-026 clr_count SHALL zero err_count and lost the next cycle and SHALL take priority over a simultaneous error increment or loss event, and SHALL NOT affect state.
REQ-027 err_pulse SHALL never assert outside LOCKED, including on the mismatch that ends CHECK.

Reset
REQ-028 reset=0 SHALL asynchronously force state HUNT, h=0, all counters 0, locked=0, err_pulse=0, err_count=0, lost=0.
REQ-029 Reset asserted mid-lock SHALL discard all lock state; after release a full 9-bit load plus LOCK_CNT matches is needed to relock.

Structure
REQ-030 Shared package prbs_pkg SHALL hold the tap constant (taps 8,7,6,3,0), the history width 9, and the state enum.
REQ-031 The loadable 9-bit reference generator (h plus p) SHALL be a sub-module named prbs9_model; the FSM and counters SHALL stay in prbs9_checker.

Verification
REQ-032 Clean stream from a seed-1 9-bit generator with continuous valid -> locked=1 exactly 9+16 accepted bits after reset release; err_count stays 0.
REQ-033 Locked, invert one bit -> err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
REQ-034 Locked, invert 4 bits within 64 valid bits -> locked=0 after the 4th, lost=1; clean stream resumes -> relock after 25 valid bits; err_count=4.
REQ-035 All-zero input for 100 valid bits -> locked stays 0, state stays HUNT, err_pulse never asserts.
REQ-036 Clean stream with in_valid random at 30% duty -> same lock point counted in valid bits; no errors.
REQ-037 With ERR_W=3, 20 isolated errors, each in a separate window -> err_count saturates at 7; clr_count together with an error -> err_count=0.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: constants and types shared by the PRBS-9 checker slice.
//   HIST_W        - length of the PRBS-9 history register
//   PRBS9_TAPS    - history taps feeding the prediction (bits 8,7,6,3,0)
//   state_t       - checker state encoding
//   prbs9_predict - next expected bit from a 9-bit history (h[8] newest)
package prbs_pkg;

    localparam int HIST_W = 9;

    localparam logic [HIST_W-1:0] PRBS9_TAPS = 9'b1_1100_1001;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic prbs9_predict(input logic [HIST_W-1:0] h);
        return ^(h & PRBS9_TAPS);
    endfunction

endpackage

// File: rtl/prbs9_model.sv
// prbs9_model: loadable PRBS-9 reference generator.
//   clk, reset - clock and asynchronous active-low reset
//   shift_en   - shift one bit into the history this cycle
//   use_ref    - 1: shift the own prediction (free-running), 0: shift din
//   din        - received bit to load while not free-running
//   hist       - 9-bit history, hist[8] is the newest bit
//   pred       - predicted next bit of the sequence
module prbs9_model
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              use_ref,
    input  logic              din,
    output logic [HIST_W-1:0] hist,
    output logic              pred
);

    logic shift_bit;

    always_comb begin
        pred      = prbs9_predict(hist);
        shift_bit = use_ref ? pred : din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {shift_bit, hist[HIST_W-1:1]};
        end
    end

endmodule

// File: rtl/prbs9_checker.sv
// prbs9_checker: PRBS-9 stream checker with lock acquisition and loss.
//   clk       - clock, all state changes on its rising edge
//   reset     - asynchronous active-low reset
//   in_valid  - in_bit is sampled this cycle
//   in_bit    - received serial PRBS bit, oldest first
//   clr_count - synchronous clear of err_count and lost
//   locked    - checker is in LOCKED
//   err_pulse - one-cycle pulse per mismatched bit while LOCKED
//   err_count - saturating count of mismatches while LOCKED
//   lost      - sticky: lock was lost since reset or the last clr_count
module prbs9_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 4,
    parameter int WIN_LEN  = 64,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             lost
);

    localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW_W = (LOSS_THR > 1) ? $clog2(LOSS_THR) : 1;

    state_t            state, state_n;
    logic [3:0]        hunt_cnt, hunt_cnt_n;
    logic [MC_W-1:0]   match_cnt, match_cnt_n;
    logic [WC_W-1:0]   win_cnt, win_cnt_n;
    logic [EW_W-1:0]   win_err, win_err_n;
    logic              mismatch;
    logic              loss;
    logic [HIST_W-1:0] hist;
    logic              pred;

    prbs9_model u_model (
        .clk      (clk),
        .reset    (reset),
        .shift_en (in_valid),
        .use_ref  (state == ST_LOCKED),
        .din      (in_bit),
        .hist     (hist),
        .pred     (pred)
    );

    always_comb begin
        state_n     = state;
        hunt_cnt_n  = hunt_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        mismatch    = 1'b0;
        loss        = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (hunt_cnt == 4'd8) begin
                        hunt_cnt_n = '0;
                        // The history after this shift is the one CHECK starts from;
                        // an all-zero history would predict zeros forever.
                        if ({in_bit, hist[HIST_W-1:1]} != '0) begin
                            state_n     = ST_CHECK;
                            match_cnt_n = '0;
                        end
                    end else begin
                        hunt_cnt_n = hunt_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (in_bit != pred) begin
                        state_n    = ST_HUNT;
                        hunt_cnt_n = '0;
                    end else if (match_cnt == MC_W'(LOCK_CNT - 1)) begin
                        state_n     = ST_LOCKED;
                        match_cnt_n = '0;
                        win_cnt_n   = '0;
                        win_err_n   = '0;
                    end else begin
                        match_cnt_n = match_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    mismatch = (in_bit != pred);
                    if (win_cnt == WC_W'(WIN_LEN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + 1'b1;
                    end
                    // An error on the wrap bit still belongs to the closing window.
                    if (mismatch) begin
                        if (win_err == EW_W'(LOSS_THR - 1)) begin
                            loss       = 1'b1;
                            state_n    = ST_HUNT;
                            hunt_cnt_n = '0;
                        end else if (win_cnt != WC_W'(WIN_LEN - 1)) begin
                            win_err_n = win_err + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n    = ST_HUNT;
                    hunt_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HUNT;
            hunt_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            lost      <= 1'b0;
        end else begin
            state     <= state_n;
            hunt_cnt  <= hunt_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            locked    <= (state_n == ST_LOCKED);
            err_pulse <= mismatch;
            if (clr_count) begin
                err_count <= '0;
                lost      <= 1'b0;
            end else begin
                if (mismatch && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
                if (loss) begin
                    lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker: self-checking bench for prbs9_checker (default
// parameters) plus a second instance with a 3-bit error counter.
module tb_prbs9_checker;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_THR = 4;
    localparam int WIN_LEN  = 64;
    localparam int ERR_W    = 16;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             clr_count = 1'b0;
    logic             locked, err_pulse, lost;
    logic [ERR_W-1:0] err_count;
    logic             locked3, err_pulse3, lost3;
    logic [2:0]       err_count3;

    always #5 clk = ~clk;

    prbs9_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_THR (LOSS_THR),
        .WIN_LEN  (WIN_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_count (clr_count),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .lost      (lost)
    );

    prbs9_checker #(
        .ERR_W (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_count (clr_count),
        .locked    (locked3),
        .err_pulse (err_pulse3),
        .err_count (err_count3),
        .lost      (lost3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_seen = 0;
    int locked_seen = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence source: s[n+9] = s[n+8]^s[n+7]^s[n+6]^s[n+3]^s[n], seed 1.
    bit g_q[$];

    task automatic gen_reset();
        g_q.delete();
        g_q.push_back(1'b1);
        repeat (8) g_q.push_back(1'b0);
    endtask

    task automatic gen_next(output bit b);
        bit nb;
        b  = g_q[0];
        nb = g_q[0] ^ g_q[3] ^ g_q[6] ^ g_q[7] ^ g_q[8];
        g_q.push_back(nb);
        void'(g_q.pop_front());
    endtask

    // Behavioural checker model: window of the last 9 reference bits, oldest first.
    bit m_hist[$];
    int m_loaded, m_run, m_win_pos, m_win_err, m_err_cnt;
    bit m_locked, m_lost, m_pulse;

    task automatic model_reset();
        m_hist.delete();
        repeat (9) m_hist.push_back(1'b0);
        m_loaded  = 0;
        m_run     = 0;
        m_win_pos = 0;
        m_win_err = 0;
        m_err_cnt = 0;
        m_locked  = 1'b0;
        m_lost    = 1'b0;
        m_pulse   = 1'b0;
    endtask

    task automatic model_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit pr;
        int ones;
        m_pulse = 1'b0;
        if (v) begin
            pr = m_hist[0] ^ m_hist[3] ^ m_hist[6] ^ m_hist[7] ^ m_hist[8];
            if (m_locked) begin
                model_push(pr);
                m_win_pos++;
                if (b != pr) begin
                    m_pulse = 1'b1;
                    if (m_err_cnt < ERR_MAX) m_err_cnt++;
                    m_win_err++;
                    if (m_win_err == LOSS_THR) begin
                        m_locked = 1'b0;
                        m_lost   = 1'b1;
                        m_loaded = 0;
                    end
                end
                if (m_locked && m_win_pos == WIN_LEN) begin
                    m_win_pos = 0;
                    m_win_err = 0;
                end
            end else if (m_loaded < 9) begin
                model_push(b);
                m_loaded++;
                if (m_loaded == 9) begin
                    ones = 0;
                    foreach (m_hist[i]) ones += int'(m_hist[i]);
                    if (ones == 0) m_loaded = 0;
                    else m_run = 0;
                end
            end else begin
                model_push(b);
                if (b == pr) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_locked  = 1'b1;
                        m_win_pos = 0;
                        m_win_err = 0;
                    end
                end else begin
                    m_loaded = 0;
                end
            end
        end
        if (c) begin
            m_err_cnt = 0;
            m_lost    = 1'b0;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        in_valid  = v;
        in_bit    = b;
        clr_count = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
        if (err_pulse) pulse_seen++;
        if (locked) locked_seen++;
        cmp("model_locked", int'(locked), int'(m_locked));
        cmp("model_err_pulse", int'(err_pulse), int'(m_pulse));
        cmp("model_err_count", int'(err_count), m_err_cnt);
        cmp("model_lost", int'(lost), int'(m_lost));
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        gen_next(b);
        step(1'b1, b ^ flip, c);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clr_count = 1'b0;
        #1;
        cmp("rst_locked", int'(locked), 0);
        cmp("rst_err_pulse", int'(err_pulse), 0);
        cmp("rst_err_count", int'(err_count), 0);
        cmp("rst_lost", int'(lost), 0);
        cmp("rst_err_count3", int'(err_count3), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        gen_reset();
    endtask

    typedef struct {
        string name;
        int    nbits;
        bit    flip_first;
        bit    exp_locked;
        int    exp_cnt;
        bit    exp_lost;
        int    exp_pulses;
    } seg_t;

    seg_t segs[8];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v, b, f, c;
        int nv, cyc;

        segs[0] = '{"prelock",  24, 1'b0, 1'b0, 0, 1'b0, 0};
        segs[1] = '{"lock",      1, 1'b0, 1'b1, 0, 1'b0, 0};
        segs[2] = '{"err1",     10, 1'b1, 1'b1, 1, 1'b0, 1};
        segs[3] = '{"err2",     10, 1'b1, 1'b1, 2, 1'b0, 1};
        segs[4] = '{"err3",     10, 1'b1, 1'b1, 3, 1'b0, 1};
        segs[5] = '{"err4_loss", 1, 1'b1, 1'b0, 4, 1'b1, 1};
        segs[6] = '{"rehunt",   24, 1'b0, 1'b0, 4, 1'b1, 0};
        segs[7] = '{"relock",    1, 1'b0, 1'b1, 4, 1'b1, 0};

        #2;
        do_reset();

        // Lock, isolated errors, loss on the 4th error in a window, relock.
        foreach (segs[i]) begin
            pulse_seen = 0;
            for (int k = 0; k < segs[i].nbits; k++) send(segs[i].flip_first && k == 0, 1'b0);
            cmp({segs[i].name, "_locked"}, int'(locked), int'(segs[i].exp_locked));
            cmp({segs[i].name, "_err_count"}, int'(err_count), segs[i].exp_cnt);
            cmp({segs[i].name, "_lost"}, int'(lost), int'(segs[i].exp_lost));
            cmp({segs[i].name, "_pulses"}, pulse_seen, segs[i].exp_pulses);
        end

        // clr_count clears count and sticky loss but keeps lock.
        send(1'b0, 1'b1);
        cmp("clr_err_count", int'(err_count), 0);
        cmp("clr_lost", int'(lost), 0);
        cmp("clr_locked", int'(locked), 1);

        // Reset while locked: full reload plus LOCK_CNT matches needed.
        do_reset();
        repeat (24) send(1'b0, 1'b0);
        cmp("rst_relock_24", int'(locked), 0);
        send(1'b0, 1'b0);
        cmp("rst_relock_25", int'(locked), 1);

        // All-zero input never locks and never pulses.
        do_reset();
        pulse_seen  = 0;
        locked_seen = 0;
        repeat (100) step(1'b1, 1'b0, 1'b0);
        cmp("zero_locked_cycles", locked_seen, 0);
        cmp("zero_pulses", pulse_seen, 0);
        cmp("zero_err_count", int'(err_count), 0);

        // Sparse valid: lock point counted in accepted bits only.
        do_reset();
        pulse_seen = 0;
        nv  = 0;
        cyc = 0;
        while (nv < 40 && cyc < 2000) begin
            v = ($urandom_range(0, 9) < 3);
            if (v) gen_next(b);
            else b = 1'($urandom_range(0, 1));
            step(v, b, 1'b0);
            if (v) nv++;
            cmp("duty_locked", int'(locked), int'(nv >= 25));
            cyc++;
        end
        cmp("duty_valid_budget", nv, 40);
        cmp("duty_pulses", pulse_seen, 0);

        // 3-bit counter saturation with one error per window.
        do_reset();
        repeat (25) send(1'b0, 1'b0);
        cmp("sat_locked", int'(locked3), 1);
        for (int k = 1; k <= 20; k++) begin
            send(1'b1, 1'b0);
            repeat (69) send(1'b0, 1'b0);
            cmp("sat_err_count", int'(err_count3), (k < 7) ? k : 7);
            cmp("sat_locked_k", int'(locked3), 1);
        end
        send(1'b1, 1'b1);
        cmp("sat_clr_with_err", int'(err_count3), 0);
        cmp("sat_clr_lost", int'(lost3), 0);
        cmp("full_clr_with_err", int'(err_count), 0);

        // Randomized traffic against the model: sparse errors, then dense errors.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            f = (n < 1500) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 299) == 0);
            if (v) begin
                gen_next(b);
                b = b ^ f;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(v, b, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
